// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, widths, helpers.
package pll_seq_pkg;

  localparam int STATE_W    = 3;
  localparam int LOST_CNT_W = 8;

  // state     | meaning
  // WAIT_LOCK | PLL not locked (or lock just lost); downstream held in reset
  // STABLE    | lock seen, qualifying that it stays high
  // RST_HOLD  | lock qualified, downstream reset still held
  // POWERUP   | downstream reset released, PSRAM power-up wait running
  // READY     | memory path ready; stays here while locked
  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RST_HOLD  = 3'd2,
    POWERUP   = 3'd3,
    READY     = 3'd4
  } pll_state_e;

  // Largest of three cycle counts; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer that brings the asynchronous PLL lock flag into clk.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the async input through the chain; cleared by reset so lock reads low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies PLL lock, sequences the clk-domain reset and the PSRAM power-up wait.
// Any lock loss after qualification restarts the whole sequence and is counted.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 1024,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int POWERUP_CYCLES  = 12150
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  output logic                  rst_o,
  output logic                  powerup_done,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt,
  output logic [STATE_W-1:0]    state_o
);

  localparam int CNT_MAX = max3(STABLE_CYCLES, RST_HOLD_CYCLES, POWERUP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of a phase is reached when it holds N-1.
  localparam logic [CNT_W-1:0] STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_HOLD_TC = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] POWERUP_TC = CNT_W'(POWERUP_CYCLES - 1);

  logic                  lock_s;
  pll_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOST_CNT_W-1:0] lost_q, lost_d;
  logic                  rst_o_q, rst_o_d;
  logic                  pd_q, pd_d;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  // Register state, shared counter, loss counter and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      lost_q  <= '0;
      rst_o_q <= 1'b1;
      pd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      rst_o_q <= rst_o_d;
      pd_q    <= pd_d;
    end
  end

  // Next state, counter and loss count; outputs derived from the next state so
  // they change on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    lost_d  = lost_q;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        // A drop before qualification is treated as a glitch, not a loss.
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_TC) state_d = RST_HOLD;
      end
      RST_HOLD, POWERUP, READY: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (lost_q != '1) lost_d = lost_q + LOST_CNT_W'(1);
        end else if (state_q == RST_HOLD && cnt_q == RST_HOLD_TC) begin
          state_d = POWERUP;
        end else if (state_q == POWERUP && cnt_q == POWERUP_TC) begin
          state_d = READY;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Counter is idle in WAIT_LOCK/READY and restarts from 0 on every change.
    if (state_d != state_q || state_q == WAIT_LOCK || state_q == READY) begin
      cnt_d = '0;
    end

    rst_o_d = (state_d != POWERUP) && (state_d != READY);
    pd_d    = (state_d == READY);
  end

  assign rst_o         = rst_o_q;
  assign powerup_done  = pd_q;
  assign lock_lost_cnt = lost_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

  localparam int SY = 2;
  localparam int S  = 8;
  localparam int R  = 4;
  localparam int P  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       rst_o;
  logic       powerup_done;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: h = consecutive edges the FSM has sampled lock_s high.
  int   m_h    = 0;
  int   m_lost = 0;
  logic sh [SY];

  typedef struct {
    logic       r;
    logic       l;
    int         n;
    logic [2:0] st;
    logic       ro;
    logic       pd;
    logic [7:0] lc;
  } vec_t;

  vec_t tbl[$];

  pll_lock_sequencer #(
    .SYNC_STAGES     (SY),
    .STABLE_CYCLES   (S),
    .RST_HOLD_CYCLES (R),
    .POWERUP_CYCLES  (P)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock      (pll_lock),
    .rst_o         (rst_o),
    .powerup_done  (powerup_done),
    .lock_lost_cnt (lock_lost_cnt),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  function automatic int mstate(input int h);
    if (h == 0)             return 0;
    if (h < 1 + S)          return 1;
    if (h < 1 + S + R)      return 2;
    if (h < 1 + S + R + P)  return 3;
    return 4;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic step(input logic r, input logic l);
    logic ls;
    rst      = r;
    pll_lock = l;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_h = 0;
      m_lost = 0;
      for (int i = 0; i < SY; i++) sh[i] = 1'b0;
    end else begin
      ls = sh[SY-1];
      if (ls) begin
        if (m_h < 1 + S + R + P) m_h++;
      end else begin
        if (m_h >= 1 + S) m_lost = (m_lost >= 255) ? 255 : m_lost + 1;
        m_h = 0;
      end
      for (int i = SY - 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = l;
    end
    #1;
    chk($sformatf("cyc%0d state", cyc), int'(state_o), mstate(m_h));
    chk($sformatf("cyc%0d rst_o", cyc), int'(rst_o), (mstate(m_h) < 3) ? 1 : 0);
    chk($sformatf("cyc%0d powerup_done", cyc), int'(powerup_done), (mstate(m_h) == 4) ? 1 : 0);
    chk($sformatf("cyc%0d lock_lost_cnt", cyc), int'(lock_lost_cnt), m_lost);
  endtask

  task automatic addv(input logic r, input logic l, input int n, input logic [2:0] st,
                      input logic ro, input logic pd, input logic [7:0] lc);
    vec_t v;
    v.r = r; v.l = l; v.n = n; v.st = st; v.ro = ro; v.pd = pd; v.lc = lc;
    tbl.push_back(v);
  endtask

  task automatic run_until(input int target, input int bound, input string nm);
    int k;
    k = 0;
    while (mstate(m_h) != target && k < bound) begin
      step(1'b0, 1'b1);
      k++;
    end
    chk({nm, " reached in budget"}, (mstate(m_h) == target) ? 1 : 0, 1);
  endtask

  initial begin
    for (int i = 0; i < SY; i++) sh[i] = 1'b0;

    // reset with lock high
    addv(1, 1, 1, 3'd0, 1, 0, 8'd0);
    addv(1, 1, 1, 3'd0, 1, 0, 8'd0);
    addv(1, 1, 1, 3'd0, 1, 0, 8'd0);
    // first lock-up: lock_s rises after 2 edges, STABLE on the 3rd
    addv(0, 1, 2,  3'd0, 1, 0, 8'd0);
    addv(0, 1, 1,  3'd1, 1, 0, 8'd0);
    addv(0, 1, 7,  3'd1, 1, 0, 8'd0);
    addv(0, 1, 1,  3'd2, 1, 0, 8'd0);
    addv(0, 1, 3,  3'd2, 1, 0, 8'd0);
    addv(0, 1, 1,  3'd3, 0, 0, 8'd0);
    addv(0, 1, 19, 3'd3, 0, 0, 8'd0);
    addv(0, 1, 1,  3'd4, 0, 1, 8'd0);
    addv(0, 1, 5,  3'd4, 0, 1, 8'd0);
    // drop lock in READY: seen through the 2-flop synchronizer
    addv(0, 0, 2, 3'd4, 0, 1, 8'd0);
    addv(0, 0, 1, 3'd0, 1, 0, 8'd1);
    // relock: full sequence again
    addv(0, 1, 2,  3'd0, 1, 0, 8'd1);
    addv(0, 1, 1,  3'd1, 1, 0, 8'd1);
    addv(0, 1, 8,  3'd2, 1, 0, 8'd1);
    addv(0, 1, 4,  3'd3, 0, 0, 8'd1);
    addv(0, 1, 19, 3'd3, 0, 0, 8'd1);
    addv(0, 1, 1,  3'd4, 0, 1, 8'd1);

    foreach (tbl[i]) begin
      repeat (tbl[i].n) step(tbl[i].r, tbl[i].l);
      chk($sformatf("vec%0d state", i), int'(state_o), int'(tbl[i].st));
      chk($sformatf("vec%0d rst_o", i), int'(rst_o), int'(tbl[i].ro));
      chk($sformatf("vec%0d powerup_done", i), int'(powerup_done), int'(tbl[i].pd));
      chk($sformatf("vec%0d lock_lost_cnt", i), int'(lock_lost_cnt), int'(tbl[i].lc));
    end

    // Glitch during STABLE at count 5 (h=6): one low lock_s sample
    step(1, 1);
    step(1, 1);
    repeat (6) step(0, 1);
    step(0, 0);
    step(0, 1);
    chk("glitch pre state", int'(state_o), 1);
    step(0, 1);
    chk("glitch state", int'(state_o), 0);
    chk("glitch lost", int'(lock_lost_cnt), 0);
    step(0, 1);
    chk("glitch requal state", int'(state_o), 1);
    repeat (7) step(0, 1);
    chk("glitch full qual", int'(state_o), 1);
    step(0, 1);
    chk("glitch rst_hold", int'(state_o), 2);
    chk("glitch rst_o", int'(rst_o), 1);
    run_until(4, 100, "glitch ready");

    // 260 drop/relock cycles, each reaching POWERUP
    for (int k = 0; k < 260; k++) begin
      repeat (3) step(0, 0);
      run_until(3, 64, $sformatf("loop%0d powerup", k));
    end
    chk("saturated lost", int'(lock_lost_cnt), 255);

    // rst mid-POWERUP
    repeat (5) step(0, 1);
    chk("pre-rst state", int'(state_o), 3);
    step(1, 1);
    chk("rst state", int'(state_o), 0);
    chk("rst rst_o", int'(rst_o), 1);
    chk("rst powerup_done", int'(powerup_done), 0);
    chk("rst lost", int'(lock_lost_cnt), 0);
    run_until(4, 100, "post-rst ready");
    chk("post-rst powerup_done", int'(powerup_done), 1);

    // Randomized lock activity with occasional reset
    for (int k = 0; k < 200; k++) begin
      logic l;
      int   len;
      l   = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 45);
      for (int j = 0; j < len; j++) begin
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, l);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
